// File: rtl/display_decoder.sv
// display_decoder: samples an active-low multiplexed seven-segment bus, waits
// for each anode slot to settle and decodes it back into BCD digits, blank
// (blink-off) flags, decimal points, a frame-complete pulse and a sticky error.
module display_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       master_clock,
  input  logic       rst,
  input  logic [7:0] seg,
  input  logic [3:0] an,
  output logic [3:0] digit_1,
  output logic [3:0] digit_2,
  output logic [3:0] digit_3,
  output logic [3:0] digit_4,
  output logic [3:0] blank,
  output logic [3:0] dp,
  output logic       frame_done,
  output logic       err
);

  localparam logic [7:0] THRESH    = 8'(STABLE_CYCLES);
  localparam logic [7:0] THRESH_M1 = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  logic [11:0] sync1_reg;
  logic [11:0] sync2_reg;
  logic [11:0] prev_reg;
  logic [11:0] accepted_reg;
  logic        accept_reg;
  logic [7:0]  cnt_reg;
  state_t      state_reg;
  logic        sample_changed;

  logic [3:0]  acc_an;
  logic [7:0]  acc_seg;
  logic [3:0]  anode_low;
  logic        multi_low;
  logic        one_low;
  logic [3:0]  seg_value;
  logic        seg_blank;
  logic        seg_illegal;
  logic [3:0]  slot_hit;
  logic [3:0]  mask_reg;
  logic [3:0]  mask_next;
  logic        frame_done_reg;
  logic        err_reg;
  logic [3:0]  digit_bus [4];

  // Two-flop synchronizer plus one more stage holding the previous sample;
  // the bus idles all-ones, so that is what the pipeline starts from.
  always_ff @(posedge master_clock or negedge rst) begin
    if (!rst) begin
      sync1_reg <= '1;
      sync2_reg <= '1;
      prev_reg  <= '1;
    end else begin
      sync1_reg <= {an, seg};
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign sample_changed = (sync2_reg != prev_reg);

  // Stability filter FSM: restart on any change, accept once at the threshold,
  // then sit in HELD until the sample moves again.
  always_ff @(posedge master_clock or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 8'd0;
      accept_reg   <= 1'b0;
      accepted_reg <= '1;
    end else begin
      accept_reg <= 1'b0;
      if (sample_changed) begin
        state_reg <= SETTLE;
        cnt_reg   <= 8'd0;
      end else begin
        case (state_reg)
          SETTLE: begin
            if (cnt_reg == THRESH_M1) begin
              cnt_reg      <= THRESH;
              state_reg    <= HELD;
              accept_reg   <= 1'b1;
              accepted_reg <= sync2_reg;
            end else begin
              cnt_reg <= cnt_reg + 8'd1;
            end
          end
          default: begin
            state_reg <= state_reg;
          end
        endcase
      end
    end
  end

  assign acc_an    = accepted_reg[11:8];
  assign acc_seg   = accepted_reg[7:0];
  assign anode_low = ~acc_an;
  // Clearing the lowest set bit leaves something only if two or more anodes are low.
  assign multi_low = |(anode_low & (anode_low - 4'd1));
  assign one_low   = (|anode_low) & ~multi_low;
  assign slot_hit  = {4{accept_reg & one_low}} & anode_low;
  assign mask_next = mask_reg | slot_hit;

  // Active-low segment pattern to BCD, with the all-off blink pattern kept apart.
  always_comb begin
    seg_value   = 4'h0;
    seg_blank   = 1'b0;
    seg_illegal = 1'b0;
    case (acc_seg[6:0])
      7'h40:   seg_value = 4'd0;
      7'h79:   seg_value = 4'd1;
      7'h24:   seg_value = 4'd2;
      7'h30:   seg_value = 4'd3;
      7'h19:   seg_value = 4'd4;
      7'h12:   seg_value = 4'd5;
      7'h02:   seg_value = 4'd6;
      7'h78:   seg_value = 4'd7;
      7'h00:   seg_value = 4'd8;
      7'h10:   seg_value = 4'd9;
      7'h7F:   seg_blank = 1'b1;
      default: seg_illegal = 1'b1;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      logic [3:0] digit_reg;
      logic       blank_reg;
      logic       dp_reg;

      // Per-slot capture; a blank pattern keeps the old digit visible underneath.
      always_ff @(posedge master_clock or negedge rst) begin
        if (!rst) begin
          digit_reg <= 4'h0;
          blank_reg <= 1'b0;
          dp_reg    <= 1'b0;
        end else if (slot_hit[gi]) begin
          dp_reg <= ~acc_seg[7];
          if (seg_blank) begin
            blank_reg <= 1'b1;
          end else begin
            blank_reg <= 1'b0;
            digit_reg <= seg_illegal ? 4'hF : seg_value;
          end
        end
      end

      assign digit_bus[gi] = digit_reg;
      assign blank[gi]     = blank_reg;
      assign dp[gi]        = dp_reg;
    end
  endgenerate

  // Frame tracker and sticky error; both update on the same edge as the digits.
  always_ff @(posedge master_clock or negedge rst) begin
    if (!rst) begin
      mask_reg       <= 4'h0;
      frame_done_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      frame_done_reg <= (|slot_hit) && (mask_next == 4'hF);
      mask_reg       <= (mask_next == 4'hF) ? 4'h0 : mask_next;
      if (accept_reg && (multi_low || (one_low && seg_illegal))) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign digit_1    = digit_bus[3];
  assign digit_2    = digit_bus[2];
  assign digit_3    = digit_bus[1];
  assign digit_4    = digit_bus[0];
  assign frame_done = frame_done_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_display_decoder.sv
// Bench for display_decoder: directed scans plus randomized slots, checked
// against a slot-level reference model that works from whole held samples.
module tb_display_decoder;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] seg;
  logic [3:0] an;
  logic [3:0] d1, d2, d3, d4, blank, dp;
  logic       fd, err;

  logic [7:0] seg1;
  logic [3:0] an1;
  logic [3:0] e1, e2, e3, e4, e_blank, e_dp;
  logic       e_fd, e_err;

  always #5 clk = ~clk;

  display_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .master_clock(clk), .rst(rst), .seg(seg), .an(an),
    .digit_1(d1), .digit_2(d2), .digit_3(d3), .digit_4(d4),
    .blank(blank), .dp(dp), .frame_done(fd), .err(err)
  );

  display_decoder #(.STABLE_CYCLES(1)) dut1 (
    .master_clock(clk), .rst(rst), .seg(seg1), .an(an1),
    .digit_1(e1), .digit_2(e2), .digit_3(e3), .digit_4(e4),
    .blank(e_blank), .dp(e_dp), .frame_done(e_fd), .err(e_err)
  );

  int total = 0;
  int bad = 0;
  int fd_count = 0;
  int fd1_count = 0;

  // Count frame_done pulses away from the active edge.
  always @(negedge clk) begin
    if (fd === 1'b1) fd_count++;
    if (e_fd === 1'b1) fd1_count++;
  end

  // ---------------- reference model ----------------
  logic [6:0] legal_pats [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [3:0] m_digit [4];
  logic [3:0] m_blank, m_dp, m_mask;
  logic       m_err;
  int         m_frames = 0;

  function automatic int pat_value(input logic [6:0] p);
    for (int k = 0; k < 10; k++) if (legal_pats[k] == p) return k;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_digit[k] = 4'h0;
    m_blank = 4'h0; m_dp = 4'h0; m_mask = 4'h0; m_err = 1'b0;
  endtask

  // A slot that was held long enough counts as one accepted display update.
  task automatic model_accept(input logic [3:0] a, input logic [7:0] s);
    int lows;
    int slot;
    int v;
    lows = $countones(~a);
    if (lows == 0) return;
    if (lows > 1) begin m_err = 1'b1; return; end
    slot = 0;
    for (int k = 0; k < 4; k++) if (a[k] == 1'b0) slot = k;
    m_dp[slot] = ~s[7];
    if (s[6:0] == 7'h7F) begin
      m_blank[slot] = 1'b1;
    end else begin
      v = pat_value(s[6:0]);
      m_blank[slot] = 1'b0;
      if (v < 0) begin m_digit[slot] = 4'hF; m_err = 1'b1; end
      else m_digit[slot] = v[3:0];
    end
    m_mask[slot] = 1'b1;
    if (m_mask == 4'hF) begin m_frames++; m_mask = 4'h0; end
  endtask

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s.digit_1", tag), {28'd0, d1}, {28'd0, m_digit[3]});
    chk($sformatf("%s.digit_2", tag), {28'd0, d2}, {28'd0, m_digit[2]});
    chk($sformatf("%s.digit_3", tag), {28'd0, d3}, {28'd0, m_digit[1]});
    chk($sformatf("%s.digit_4", tag), {28'd0, d4}, {28'd0, m_digit[0]});
    chk($sformatf("%s.blank", tag), {28'd0, blank}, {28'd0, m_blank});
    chk($sformatf("%s.dp", tag), {28'd0, dp}, {28'd0, m_dp});
    chk($sformatf("%s.err", tag), {31'd0, err}, {31'd0, m_err});
    chk($sformatf("%s.frames", tag), fd_count, m_frames);
  endtask

  task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
    an = a; seg = s;
    tick(n);
    if (n >= STABLE + 1) model_accept(a, s);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0; an = 4'hF; seg = 8'hFF;
    tick(2);
    model_reset();
    check_all(tag);
    rst = 1'b1;
    tick(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] ra;
    logic [7:0] rs;
    int         rd;
    int         r;

    rst = 1'b0; an = 4'b1110; seg = 8'hC0; an1 = 4'hF; seg1 = 8'hFF;
    model_reset();
    tick(3);
    check_all("reset");
    rst = 1'b1;
    tick(10);
    model_accept(4'b1110, 8'hC0);
    check_all("reset_release");

    // Full frame 3,5,8,9 with an exact-latency probe on the first slot.
    do_reset("reset_pre_frame");
    an = 4'b0111; seg = 8'hB0;
    tick(7);
    chk("latency_before", {28'd0, d1}, 32'd0);
    tick(1);
    chk("latency_at", {28'd0, d1}, 32'd3);
    tick(12);
    model_accept(4'b0111, 8'hB0);
    hold(4'b1011, 8'h92, 20);
    hold(4'b1101, 8'h80, 20);
    check_all("frame_3of4");
    hold(4'b1110, 8'h90, 20);
    check_all("frame_full");

    // Glitches shorter than STABLE+1 cycles vanish; exactly STABLE+1 is taken.
    hold(4'b1110, 8'hF9, 3);
    hold(4'hF, 8'hFF, 10);
    check_all("glitch3");
    hold(4'b1110, 8'hF9, 4);
    hold(4'hF, 8'hFF, 10);
    check_all("glitch4");
    hold(4'b1110, 8'hF9, 5);
    hold(4'hF, 8'hFF, 10);
    check_all("held5");

    // Blink on the third position, then a legal frame clears it.
    hold(4'b0111, 8'hB0, 20);
    hold(4'b1011, 8'h92, 20);
    hold(4'b1101, 8'hFF, 20);
    hold(4'b1110, 8'h90, 20);
    check_all("blink");
    hold(4'b0111, 8'hB0, 20);
    hold(4'b1011, 8'h92, 20);
    hold(4'b1101, 8'h80, 20);
    hold(4'b1110, 8'h90, 20);
    check_all("unblink");

    // Error paths.
    hold(4'b1110, 8'hAA, 20);
    check_all("err_seg");
    hold(4'b0011, 8'hC0, 20);
    check_all("err_multi");
    hold(4'hF, 8'hFF, 10);
    check_all("err_sticky");

    // Back-to-back minimum-length slots, two frames.
    for (int k = 0; k < 8; k++) begin
      hold(~(4'b1000 >> (k % 4)), {1'b1, legal_pats[k]}, STABLE + 1);
    end
    hold(4'hF, 8'hFF, 8);
    check_all("back_to_back");

    // STABLE_CYCLES=1 instance: 2 synchronized cycles accepted, 1 is not.
    an1 = 4'b1110; seg1 = 8'hA4;
    tick(2);
    an1 = 4'hF; seg1 = 8'hFF;
    tick(6);
    chk("s1_hold2", {28'd0, e4}, 32'd2);
    an1 = 4'b1110; seg1 = 8'h99;
    tick(1);
    an1 = 4'hF; seg1 = 8'hFF;
    tick(6);
    chk("s1_hold1", {28'd0, e4}, 32'd2);
    chk("s1_frames", fd1_count, 0);
    chk("s1_err", {31'd0, e_err}, 32'd0);

    // Reset in the middle of a settle and mid-frame discards the seen slots.
    hold(4'b0111, 8'hB0, 20);
    hold(4'b1011, 8'h92, 20);
    an = 4'b1101; seg = 8'h80;
    tick(3);
    do_reset("reset_mid");
    hold(4'b1101, 8'h80, 20);
    hold(4'b1110, 8'h90, 20);
    check_all("post_reset_half");
    hold(4'b0111, 8'hB0, 20);
    hold(4'b1011, 8'h92, 20);
    check_all("post_reset_full");

    // Randomized slots against the model.
    do_reset("reset_rand");
    for (int step = 0; step < 40; step++) begin
      r = $urandom_range(0, 99);
      if (r < 70) ra = ~(4'b0001 << $urandom_range(0, 3));
      else if (r < 85) ra = 4'hF;
      else ra = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 99);
      if (r < 55) rs = {1'($urandom_range(0, 1)), legal_pats[$urandom_range(0, 9)]};
      else if (r < 70) rs = {1'($urandom_range(0, 1)), 7'h7F};
      else rs = 8'($urandom_range(0, 255));
      rd = ($urandom_range(0, 2) == 0) ? $urandom_range(1, STABLE) : $urandom_range(STABLE + 1, STABLE + 5);
      $display("step %0d an=%b seg=%h hold=%0d", step, ra, rs, rd);
      hold(ra, rs, rd);
      hold(4'hF, 8'hFF, STABLE + 3);
      check_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_decoder.md
# display_decoder

Receive-side counterpart of the multiplexed seven-segment driver. It samples the active-low `seg`/`an` bus, waits for each anode slot to settle, and decodes the segment pattern back into BCD digits. It also reports blanked (blink-off) digits and malformed patterns. It sits beside the display driver, either as a self-check monitor in system builds or as the capture side in display benches.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical synchronized samples (1..255) required before a slot is accepted.
- `master_clock`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `seg`  in  8  cathodes, active-low; `seg[0]`=a … `seg[6]`=g, `seg[7]`=dp.
- `an`  in  4  anodes, active-low; `an[3]` leftmost → `digit_1`, `an[0]` rightmost → `digit_4`.
- `digit_1`..`digit_4`  out  4 each  last accepted BCD value per position; 4'hF = illegal pattern.
- `blank`  out  4  bit i set when slot i was last accepted with all segments a–g off; `blank[3]` ↔ `digit_1`.
- `dp`  out  4  last accepted decimal-point state per slot, active-high.
- `frame_done`  out  1  one-cycle pulse when all four slots have been accepted since the previous pulse.
- `err`  out  1  sticky; set on an illegal segment pattern or more than one anode low; cleared only by reset.

## Operation
- **Input synchronizer:** `seg` and `an` each pass through two flops before any logic.
- **Stability filter:**
  - Compare the synchronized `{an,seg}` with the previous synchronized value.
  - If they differ, the counter loads 0. If equal, it increments and saturates at `STABLE_CYCLES`.
  - Acceptance fires once, in the cycle the counter reaches `STABLE_CYCLES - 1` → `STABLE_CYCLES`.
  - No re-accept until the sample changes.
- **Anode decode, evaluated at acceptance:**
  - exactly one bit low → slot index 3..0;
  - all high → idle; nothing is updated and it is not an error;
  - two or more low → set `err`, no digit update.
- **Segment decode, `seg[6:0]` active-low:**
  - 7'h40→0, 7'h79→1, 7'h24→2, 7'h30→3, 7'h19→4, 7'h12→5, 7'h02→6, 7'h78→7, 7'h00→8, 7'h10→9.
  - 7'h7F → blank: digit register holds its old value and `blank` bit = 1.
  - Any other pattern → digit = 4'hF, `blank` bit = 0, set `err`.
  - A legal digit clears that slot's `blank` bit.
  - `dp` bit = `~seg[7]` on every valid-slot acceptance, including blank.
- **Frame tracker:**
  - A 4-bit seen-mask sets the bit for each valid-slot acceptance.
  - When the mask becomes 4'hF, `frame_done` pulses in the same cycle the outputs update, and the mask clears to 0.
  - The mask then sets the bit of any acceptance that lands in that same cycle. That acceptance is not lost.
- **State machine `state`:**
  - IDLE: counter 0 after reset; waits for the first sample change.
  - SETTLE: counting.
  - HELD: accepted, waiting for a change.
  - Any sample change → SETTLE. The counter reaching the threshold → HELD.

## Timing
- **Reset (async assert, sync release), all outputs and state:**
  - `digit_1`..`digit_4` = 0, `blank` = 4'h0, `dp` = 4'h0, `frame_done` = 0, `err` = 0.
  - Seen-mask = 0, counter = 0, synchronizers = all-ones (idle bus), `state` = IDLE.
- **Latency:** a new `{an,seg}` held steady at the pins shows on the outputs 2 + `STABLE_CYCLES` + 1 cycles after its first sampling edge. The default is 7 cycles.
- A slot held for fewer than `STABLE_CYCLES` + 1 synchronized cycles is never accepted and leaves no trace.
- `err` sets in the same cycle as the acceptance that caused it.
- Reset mid-settle discards the counter and seen-mask. The first post-reset frame must contain all four slots before `frame_done` can pulse.
- An anode change with unchanged `seg` still counts as a change and restarts the settle count.

## Test plan
- **Reset:** hold `rst`=0 with `an`=4'b1110, `seg`=8'hC0 → all outputs 0, `err`=0. Release, hold 7 cycles → `digit_4`=0, `dp[0]`=0, no `frame_done`.
- **Full frame:** scan 3,5,8,9 (`seg` 8'hB0, 8'h92, 8'h80, 8'h90) on `an` 0111/1011/1101/1110, 20 cycles each → digits 3,5,8,9. Exactly one `frame_done` pulse, at the 4th acceptance.
- **Glitch rejection:** `STABLE_CYCLES`=4; drive `an`=1110, `seg`=8'hF9 for 3 cycles, then idle → `digit_4` unchanged, no `frame_done`.
- **Blink:** repeat the full-frame scan with `seg`=8'hFF on `an`=1101 → `blank`=4'b0010, `digit_3` keeps 8. The next legal frame clears `blank` to 4'b0000.
- **Errors:** `seg`=8'hAA on a valid slot → digit 4'hF, `err`=1. `an`=4'b0011 → `err`=1, no digit change. `err` stays set until reset.
- **Boundary:** `STABLE_CYCLES`=1 with a slot held exactly 2 synchronized cycles → accepted. Back-to-back frames → `frame_done` every 4th accepted slot, no dropped slot.
